// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master transfer sequencer: FSM encoding,
// spi_mode constants and the "active" qualification.
package spi_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_XFER  = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [1:0] SPI_RUN  = 2'b00;
  localparam logic [1:0] SPI_WAIT = 2'b01;
  localparam logic [1:0] SPI_STOP = 2'b10;

  // A transfer may start in run mode as an enabled master, or in wait mode
  // when the core is not configured to freeze.
  function automatic logic is_active(input logic [1:0] mode, input logic spe,
                                     input logic mstr, input logic spiswai);
    return (spe && mstr && (mode == SPI_RUN)) || ((mode == SPI_WAIT) && !spiswai);
  endfunction

endpackage

// File: rtl/spi_xfer_sequencer_if.sv
// Signal bundle between the sequencer and its surroundings (APB register
// block, baud rate generator, shift register).
interface spi_xfer_sequencer_if;
  import spi_pkg::*;

  logic [1:0] spi_mode;
  logic       spiswai;
  logic       spe;
  logic       mstr;
  logic       cpha;
  logic       send_data;
  logic       sample_tick;
  logic       shift_tick;
  logic       ss;
  logic       sclk_en;
  logic       tx_load;
  logic       tx_shift;
  logic       rx_sample;
  logic       receive_data;
  logic       abort;
  logic       busy;
  logic [3:0] bit_cnt;

  modport master (
    input  spi_mode, spiswai, spe, mstr, cpha, send_data, sample_tick, shift_tick,
    output ss, sclk_en, tx_load, tx_shift, rx_sample, receive_data, abort, busy, bit_cnt
  );

  modport slave (
    output spi_mode, spiswai, spe, mstr, cpha, send_data, sample_tick, shift_tick,
    input  ss, sclk_en, tx_load, tx_shift, rx_sample, receive_data, abort, busy, bit_cnt
  );

endinterface

// File: rtl/spi_guard_timer.sv
// Loadable down-counter with zero flag and hold; times the slave-select
// setup and hold dwell around the SCLK burst.
module spi_guard_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         hold,
  output logic         zero
);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (!hold && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/spi_xfer_sequencer.sv
// Frames one DATA_W-bit SPI transfer: slave select, SCLK enable, and the
// load/shift/sample strobes derived from the baud generator ticks.
module spi_xfer_sequencer
  import spi_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int GUARD_CYC = 2
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  spi_xfer_sequencer_if.master bus
);

  localparam logic [3:0] BITS       = 4'(DATA_W);
  localparam logic [3:0] LAST_BIT   = 4'(DATA_W - 1);
  localparam logic [3:0] GUARD_LOAD = 4'(GUARD_CYC - 1);

  logic [2:0] state_reg, state_next;
  logic [3:0] bit_cnt_reg;
  logic       tx_load_reg;
  logic       abort_reg;
  logic       first_shift_reg;

  logic freeze, busy, abort_cond, in_xfer, start, last_bit, guard_zero;

  assign freeze     = (bus.spi_mode == SPI_WAIT) && bus.spiswai;
  assign busy       = (state_reg != ST_IDLE);
  assign abort_cond = busy && !freeze && (!bus.spe || !bus.mstr || bus.spi_mode[1]);
  assign in_xfer    = (state_reg == ST_XFER) && !freeze;
  assign start      = (state_reg == ST_IDLE) && bus.send_data &&
                      is_active(bus.spi_mode, bus.spe, bus.mstr, bus.spiswai);
  assign last_bit   = bus.rx_sample && (bit_cnt_reg == LAST_BIT);

  // The timer is loaded with GUARD_CYC-1 so SETUP and HOLD each last GUARD_CYC cycles.
  spi_guard_timer #(.W(4)) u_guard (
    .clk      (PCLK),
    .rst      (PRESET),
    .load     (start || last_bit),
    .load_val (GUARD_LOAD),
    .hold     (freeze),
    .zero     (guard_zero)
  );

  always_comb begin
    state_next = state_reg;
    if (abort_cond) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE:  if (start) state_next = ST_SETUP;
        ST_SETUP: if (!freeze && guard_zero) state_next = ST_XFER;
        ST_XFER:  if (last_bit) state_next = ST_HOLD;
        ST_HOLD:  if (!freeze && guard_zero) state_next = ST_DONE;
        ST_DONE:  state_next = ST_IDLE;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_reg       <= ST_IDLE;
      bit_cnt_reg     <= '0;
      tx_load_reg     <= 1'b0;
      abort_reg       <= 1'b0;
      first_shift_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      tx_load_reg <= start;
      abort_reg   <= abort_cond;
      if (start) begin
        bit_cnt_reg <= '0;
      end else if (bus.rx_sample && (bit_cnt_reg < BITS)) begin
        bit_cnt_reg <= bit_cnt_reg + 1'b1;
      end
      // With cpha=1 the first shift edge only launches the pre-loaded bit.
      if (start) begin
        first_shift_reg <= 1'b1;
      end else if (in_xfer && bus.shift_tick) begin
        first_shift_reg <= 1'b0;
      end
    end
  end

  assign bus.ss           = !((state_reg == ST_SETUP) || (state_reg == ST_XFER) ||
                              (state_reg == ST_HOLD));
  assign bus.busy         = busy;
  assign bus.sclk_en      = in_xfer;
  assign bus.tx_load      = tx_load_reg;
  assign bus.rx_sample    = in_xfer && bus.sample_tick;
  assign bus.tx_shift     = in_xfer && bus.shift_tick && !(bus.cpha && first_shift_reg);
  assign bus.receive_data = (state_reg == ST_DONE) && !abort_cond;
  assign bus.abort        = abort_reg;
  assign bus.bit_cnt      = bit_cnt_reg;

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Directed bench for spi_xfer_sequencer with a model baud generator and a
// transfer scoreboard (expected pushed at start, observed pushed at completion).
module tb_spi_xfer_sequencer;
  import spi_pkg::*;

  typedef struct packed {
    logic [7:0] rx;
    logic [7:0] tx;
    logic [3:0] bcnt;
    logic       done;
    logic       ab;
    logic [7:0] ssl;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic force_ticks = 1'b0;
  int   tests = 0;
  int   failed = 0;
  int   n_done = 0;
  int   n_abort = 0;
  int   exp_done = 0;
  res_t exp_q[$];
  res_t obs_q[$];

  spi_xfer_sequencer_if bus();

  spi_xfer_sequencer #(.DATA_W(8), .GUARD_CYC(2)) dut (
    .PCLK   (clk),
    .PRESET (rst),
    .bus    (bus.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] rx, input logic [7:0] tx, input logic [3:0] b,
                          input logic done, input logic ab, input logic [7:0] ssl);
    res_t e;
    e = '{rx: rx, tx: tx, bcnt: b, done: done, ab: ab, ssl: ssl};
    exp_q.push_back(e);
    if (done) exp_done++;
  endtask

  task automatic pulse_send();
    bus.send_data = 1'b1;
    step();
    bus.send_data = 1'b0;
  endtask

  task automatic wait_bitcnt(input logic [3:0] v, input int lim);
    for (int i = 0; i < lim; i++) begin
      if (bus.bit_cnt == v) break;
      step();
    end
    check("wait_bitcnt", bus.bit_cnt, v);
  endtask

  task automatic wait_sclk(input int lim);
    for (int i = 0; i < lim; i++) begin
      if (bus.sclk_en) break;
      step();
    end
    check("wait_sclk_en", bus.sclk_en, 1);
  endtask

  task automatic wait_result(input string tag, input int lim);
    res_t e, o;
    for (int i = 0; i < lim; i++) begin
      if (obs_q.size() > 0) break;
      step();
    end
    check({tag, "_avail"}, (obs_q.size() > 0), 1);
    if (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      check({tag, "_rx"}, o.rx, e.rx);
      check({tag, "_tx"}, o.tx, e.tx);
      check({tag, "_bitcnt"}, o.bcnt, e.bcnt);
      check({tag, "_done"}, o.done, e.done);
      check({tag, "_abort"}, o.ab, e.ab);
      if (e.ssl != 0) check({tag, "_ss_low"}, o.ssl, e.ssl);
    end
  endtask

  // Model baud generator: ticks run only while sclk_en is high.
  initial begin
    int p;
    logic gs, gh;
    p = 0;
    bus.sample_tick = 1'b0;
    bus.shift_tick  = 1'b0;
    forever begin
      @(negedge clk);
      gs = 1'b0;
      gh = 1'b0;
      if (bus.sclk_en) begin
        gs = (p % 4 == 3);
        if (bus.cpha) gh = (p == 0) || (p % 4 == 3);
        else          gh = (p % 4 == 1);
        p++;
      end else begin
        p = 0;
      end
      bus.sample_tick = gs | force_ticks;
      bus.shift_tick  = gh | force_ticks;
    end
  end

  // Monitor: accumulate strobes per transfer, report on completion or abort.
  initial begin
    int rx, tx, ssl;
    res_t o;
    rx = 0; tx = 0; ssl = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        if (bus.tx_load) begin
          rx = 0; tx = 0; ssl = 0;
        end
        rx += int'(bus.rx_sample);
        tx += int'(bus.tx_shift);
        ssl += int'(!bus.ss);
        if (bus.receive_data || bus.abort) begin
          o = '{rx: 8'(rx), tx: 8'(tx), bcnt: bus.bit_cnt, done: bus.receive_data,
                ab: bus.abort, ssl: 8'(ssl)};
          obs_q.push_back(o);
          if (bus.receive_data) n_done++;
          if (bus.abort) n_abort++;
          $display("[TB] xfer end rx=%0d tx=%0d bit_cnt=%0d done=%0b abort=%0b ss_low=%0d",
                   rx, tx, bus.bit_cnt, bus.receive_data, bus.abort, ssl);
        end
      end
    end
  end

  initial begin
    bus.spi_mode  = SPI_RUN;
    bus.spiswai   = 1'b0;
    bus.spe       = 1'b1;
    bus.mstr      = 1'b1;
    bus.cpha      = 1'b0;
    bus.send_data = 1'b0;
    step(); step();
    check("rst_ss", bus.ss, 1);
    check("rst_busy", bus.busy, 0);
    rst = 1'b0;
    step();
    check("reset_ss", bus.ss, 1);
    check("reset_sclk_en", bus.sclk_en, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_bit_cnt", bus.bit_cnt, 0);
    check("reset_tx_load", bus.tx_load, 0);
    check("reset_abort", bus.abort, 0);
    check("reset_receive", bus.receive_data, 0);

    // Run mode, cpha=0: SETUP 2 + XFER 32 + HOLD 2 cycles of ss low.
    push_exp(8, 8, 8, 1, 0, 36);
    pulse_send();
    check("start_ss", bus.ss, 0);
    check("start_busy", bus.busy, 1);
    check("start_tx_load", bus.tx_load, 1);
    check("setup1_sclk_en", bus.sclk_en, 0);
    step();
    check("setup2_tx_load", bus.tx_load, 0);
    check("setup2_sclk_en", bus.sclk_en, 0);
    step();
    check("xfer_sclk_en", bus.sclk_en, 1);
    wait_result("cpha0", 200);
    check("cpha0_ss_after", bus.ss, 1);
    check("cpha0_busy_after", bus.busy, 0);

    // cpha=1: launch edge plus one shift sharing a cycle with the final sample.
    bus.cpha = 1'b1;
    push_exp(8, 8, 8, 1, 0, 36);
    pulse_send();
    wait_result("cpha1", 200);
    bus.cpha = 1'b0;

    // Freeze after bit 3: counters and ticks held, then resume.
    push_exp(8, 8, 8, 1, 0, 0);
    pulse_send();
    wait_bitcnt(3, 100);
    bus.spi_mode = SPI_WAIT;
    bus.spiswai  = 1'b1;
    force_ticks  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check("frz_bit_cnt", bus.bit_cnt, 3);
      check("frz_sclk_en", bus.sclk_en, 0);
      check("frz_rx_sample", bus.rx_sample, 0);
      check("frz_tx_shift", bus.tx_shift, 0);
    end
    check("frz_ss", bus.ss, 0);
    check("frz_busy", bus.busy, 1);
    bus.spi_mode = SPI_RUN;
    bus.spiswai  = 1'b0;
    force_ticks  = 1'b0;
    wait_result("freeze", 200);

    // spe dropped at bit 5: abort next cycle, then clean restart.
    push_exp(5, 5, 5, 0, 1, 0);
    pulse_send();
    wait_bitcnt(5, 100);
    bus.spe = 1'b0;
    step();
    check("abort_pulse", bus.abort, 1);
    check("abort_ss", bus.ss, 1);
    check("abort_busy", bus.busy, 0);
    check("abort_no_receive", bus.receive_data, 0);
    step();
    check("abort_one_cycle", bus.abort, 0);
    wait_result("abort", 5);
    bus.spe = 1'b1;
    push_exp(8, 8, 8, 1, 0, 36);
    pulse_send();
    check("restart_bit_cnt", bus.bit_cnt, 0);
    check("restart_tx_load", bus.tx_load, 1);
    wait_result("restart", 200);

    // send_data in XFER and in DONE ignored; the cycle after DONE is accepted.
    push_exp(8, 8, 8, 1, 0, 36);
    pulse_send();
    wait_sclk(20);
    step(); step();
    pulse_send();
    for (int i = 0; i < 200; i++) begin
      if (bus.receive_data) break;
      step();
    end
    check("b2b_receive", bus.receive_data, 1);
    bus.send_data = 1'b1;
    step();
    check("b2b_done_ignored_busy", bus.busy, 0);
    check("b2b_done_ignored_ss", bus.ss, 1);
    push_exp(8, 8, 8, 1, 0, 36);
    step();
    bus.send_data = 1'b0;
    check("b2b_accept_busy", bus.busy, 1);
    check("b2b_accept_tx_load", bus.tx_load, 1);
    wait_result("b2b_first", 5);
    wait_result("b2b_second", 200);

    // PRESET mid-XFER: outputs return to reset values asynchronously.
    pulse_send();
    wait_sclk(20);
    for (int i = 0; i < 9; i++) step();
    rst = 1'b1;
    #1;
    check("prst_ss", bus.ss, 1);
    check("prst_sclk_en", bus.sclk_en, 0);
    check("prst_busy", bus.busy, 0);
    check("prst_bit_cnt", bus.bit_cnt, 0);
    check("prst_abort", bus.abort, 0);
    check("prst_receive", bus.receive_data, 0);
    step();
    rst = 1'b0;
    step(); step();
    check("prst_after_abort", bus.abort, 0);
    check("prst_after_busy", bus.busy, 0);

    check("total_receive_data", n_done, exp_done);
    check("total_abort", n_abort, 1);
    check("leftover_results", obs_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
